// File: rtl/alu_ctrl.sv
// Sequencer in front of a registered 32-bit ALU: register file, load/ALU command handshake,
// operand issue, result writeback. Optional ALU_CTRL_R0_ZERO_EN hardwires register 0 to zero.
module alu_ctrl #(
  parameter int unsigned NREG = 8,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_ld,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  input  logic [31:0]   cmd_imm,

  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [1:0]    alu_op,
  input  logic [31:0]   alu_res,

  output logic          done_valid,
  output logic [AW-1:0] done_rd,
  output logic [31:0]   done_data,

  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          rd_q, rd_d;
  logic [31:0]            alu_a_q, alu_a_d;
  logic [31:0]            alu_b_q, alu_b_d;
  logic [1:0]             alu_op_q, alu_op_d;
  logic [NREG-1:0][31:0]  rf_q, rf_d;

  logic [NREG-1:0][31:0]  rf_view;
  logic                   wr_en;
  logic [AW-1:0]          wr_idx;
  logic [31:0]            wr_data;

  // Read-side view of the register file; register 0 may be forced to zero.
  always_comb begin
    rf_view = rf_q;
`ifdef ALU_CTRL_R0_ZERO_EN
    rf_view[0] = '0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rf_d     = rf_q;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_ld) begin
            wr_en   = 1'b1;
            wr_idx  = cmd_rd;
            wr_data = cmd_imm;
          end else begin
            alu_a_d  = rf_view[cmd_rs];
            alu_b_d  = rf_view[cmd_rt];
            alu_op_d = cmd_op;
            rd_d     = cmd_rd;
            state_d  = StExec;
          end
        end
      end
      StExec: state_d = StWb;
      StWb: begin
        wr_en   = 1'b1;
        wr_idx  = rd_q;
        wr_data = alu_res;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef ALU_CTRL_R0_ZERO_EN
    if (wr_idx == '0) begin
      wr_en = 1'b0;
    end
`endif
    if (wr_en) begin
      rf_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rd_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      rf_q     <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      rf_q     <= rf_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign done_valid = (state_q == StWb);
  assign done_rd    = rd_q;
  assign done_data  = alu_res;
  assign dbg_data   = rf_view[dbg_addr];

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural registered ALU attached to its operand ports.
module tb_alu_ctrl;

  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_ld = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rd = '0, cmd_rs = '0, cmd_rt = '0;
  logic [31:0]   cmd_imm = '0;
  logic [31:0]   alu_a, alu_b;
  logic [1:0]    alu_op;
  logic [31:0]   alu_res = '0;
  logic          done_valid;
  logic [AW-1:0] done_rd;
  logic [31:0]   done_data;
  logic [AW-1:0] dbg_addr = '0;
  logic [31:0]   dbg_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;

  alu_ctrl #(.NREG(NREG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ld     (cmd_ld),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs     (cmd_rs),
    .cmd_rt     (cmd_rt),
    .cmd_imm    (cmd_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_res    (alu_res),
    .done_valid (done_valid),
    .done_rd    (done_rd),
    .done_data  (done_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] a, b, input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return {31'd0, (a < b)};
    endcase
  endfunction

  // Registered ALU: result appears one clock after operands.
  always @(posedge clk) alu_res <= alu_model(alu_a, alu_b, alu_op);

  always @(posedge clk) if (rst_n && cmd_valid && cmd_ready) acc_cnt++;
  always @(negedge clk) if (done_valid) done_cnt++;

  typedef struct {
    logic        ld;
    logic [1:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [31:0] imm;
    logic [31:0] exp_done;
    logic [31:0] exp_dbg;
  } vec_t;

  vec_t vecs[13];
  vec_t burst[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cmd_ld  = v.ld;
    cmd_op  = v.op;
    cmd_rd  = v.rd;
    cmd_rs  = v.rs;
    cmd_rt  = v.rt;
    cmd_imm = v.imm;
  endtask

  task automatic check_dbg(input string name, input logic [2:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic apply(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    drive(v);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_wait[%0d]", idx), {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!v.ld) begin
      check($sformatf("exec_ready[%0d]", idx), {31'd0, cmd_ready}, 32'd0);
      check($sformatf("exec_done[%0d]", idx), {31'd0, done_valid}, 32'd0);
      @(negedge clk);
      check($sformatf("wb_ready[%0d]", idx), {31'd0, cmd_ready}, 32'd0);
      check($sformatf("wb_done[%0d]", idx), {31'd0, done_valid}, 32'd1);
      check($sformatf("wb_rd[%0d]", idx), {29'd0, done_rd}, {29'd0, v.rd});
      check($sformatf("wb_data[%0d]", idx), done_data, v.exp_done);
      @(negedge clk);
      check($sformatf("idle_ready[%0d]", idx), {31'd0, cmd_ready}, 32'd1);
      check($sformatf("idle_done[%0d]", idx), {31'd0, done_valid}, 32'd0);
    end
    check_dbg($sformatf("dbg[%0d]", idx), v.rd, v.exp_dbg);
  endtask

  initial begin
    logic [31:0] r0_ld, r0_add, r5_val;
    int acc0, done0;
`ifdef ALU_CTRL_R0_ZERO_EN
    r0_ld  = 32'd0;
    r0_add = 32'd0;
    r5_val = 32'd3;
`else
    r0_ld  = 32'h55;
    r0_add = 32'd8;
    r5_val = 32'd11;
`endif
    //          ld    op    rd    rs    rt    imm         done          dbg
    vecs[0]  = '{1'b1, 2'd0, 3'd1, 3'd0, 3'd0, 32'd5,  32'd0,        32'd5};
    vecs[1]  = '{1'b1, 2'd0, 3'd2, 3'd0, 3'd0, 32'd3,  32'd0,        32'd3};
    vecs[2]  = '{1'b0, 2'd0, 3'd3, 3'd1, 3'd2, 32'd0,  32'd8,        32'd8};
    vecs[3]  = '{1'b0, 2'd1, 3'd4, 3'd2, 3'd1, 32'd0,  32'hFFFFFFFE, 32'hFFFFFFFE};
    vecs[4]  = '{1'b0, 2'd3, 3'd5, 3'd4, 3'd1, 32'd0,  32'd0,        32'd0};
    vecs[5]  = '{1'b0, 2'd2, 3'd6, 3'd1, 3'd2, 32'd0,  32'd6,        32'd6};
    vecs[6]  = '{1'b0, 2'd3, 3'd7, 3'd1, 3'd4, 32'd0,  32'd1,        32'd1};
    vecs[7]  = '{1'b1, 2'd0, 3'd0, 3'd0, 3'd0, 32'h55, 32'd0,        r0_ld};
    vecs[8]  = '{1'b0, 2'd0, 3'd0, 3'd1, 3'd2, 32'd0,  32'd8,        r0_add};
    vecs[9]  = '{1'b0, 2'd0, 3'd5, 3'd0, 3'd2, 32'd0,  r5_val,       r5_val};
    vecs[10] = '{1'b0, 2'd0, 3'd1, 3'd1, 3'd1, 32'd0,  32'd10,       32'd10};
    vecs[11] = '{1'b0, 2'd0, 3'd1, 3'd1, 3'd1, 32'd0,  32'd20,       32'd20};
    vecs[12] = '{1'b0, 2'd1, 3'd2, 3'd2, 3'd2, 32'd0,  32'd0,        32'd0};
    // Burst on r1=20, r2=0, r3=8, r6=6; each depends on an earlier writeback.
    burst[0] = '{1'b0, 2'd0, 3'd7, 3'd3, 3'd6, 32'd0,  32'd14,       32'd14};
    burst[1] = '{1'b0, 2'd2, 3'd4, 3'd7, 3'd3, 32'd0,  32'd6,        32'd6};
    burst[2] = '{1'b0, 2'd1, 3'd5, 3'd4, 3'd1, 32'd0,  32'hFFFFFFF2, 32'hFFFFFFF2};

    // Reset state
    #12;
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_done", {31'd0, done_valid}, 32'd0);
    check("rst_done_rd", {29'd0, done_rd}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", {30'd0, alu_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) check_dbg($sformatf("rst_rf[%0d]", i), i[2:0], 32'd0);

    for (int i = 0; i < 13; i++) apply(vecs[i], i);

    // Held cmd_valid: accepts every 3rd cycle, one done pulse each.
    acc0  = acc_cnt;
    done0 = done_cnt;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
        check($sformatf("burst_ready[%0d]", c), {31'd0, cmd_ready}, 32'd1);
        drive(burst[c / 3]);
        cmd_valid = 1'b1;
      end else begin
        check($sformatf("burst_busy[%0d]", c), {31'd0, cmd_ready}, 32'd0);
      end
      if (c % 3 == 2) begin
        check($sformatf("burst_done[%0d]", c), {31'd0, done_valid}, 32'd1);
        check($sformatf("burst_rd[%0d]", c), {29'd0, done_rd}, {29'd0, burst[c / 3].rd});
        check($sformatf("burst_data[%0d]", c), done_data, burst[c / 3].exp_done);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("burst_accepts", acc_cnt - acc0, 32'd3);
    check("burst_dones", done_cnt - done0, 32'd3);
    for (int k = 0; k < 3; k++) check_dbg($sformatf("burst_dbg[%0d]", k), burst[k].rd,
                                          burst[k].exp_dbg);

    // Reset during EXEC of ADD r7 discards the writeback.
    @(negedge clk);
    drive('{1'b0, 2'd0, 3'd7, 3'd3, 3'd6, 32'd0, 32'd0, 32'd0});
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_exec_busy", {31'd0, cmd_ready}, 32'd0);
    done0 = done_cnt;
    rst_n = 1'b0;
    #2;
    check("rst_async_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_async_done", {31'd0, done_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_no_done", done_cnt - done0, 32'd0);
    check("rst_ready_after", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < NREG; i++) check_dbg($sformatf("rst2_rf[%0d]", i), i[2:0], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing stage directly upstream of the 32-bit registered ALU: accepts register-to-register ALU commands over a valid/ready handshake, reads operands from an internal register file, drives the ALU's `a`/`b`/`op` inputs, captures the ALU result one clock later and writes it back to the destination register. It also accepts immediate-load commands so the register file can be initialised, and it provides a debug read port for inspection.

## Interface
- `NREG`, 8: number of 32-bit registers; must be a power of 2, ≥ 2. `AW = log2(NREG)`.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_ld`  in  1  1 = load `cmd_imm` into `cmd_rd`; 0 = ALU command.
- `cmd_op`  in  2  ALU op: 0 add, 1 sub, 2 xor, 3 unsigned set-less-than.
- `cmd_rd`, `cmd_rs`, `cmd_rt`  in  AW  destination, operand-A and operand-B register indices.
- `cmd_imm`  in  32  load value.
- `alu_a`, `alu_b`  out  32  ALU operands, registered.
- `alu_op`  out  2  ALU op, registered.
- `alu_res`  in  32  ALU result; valid one clock after the operands are presented.
- `done_valid`  out  1  one-cycle pulse: ALU result being written back.
- `done_rd`  out  AW  destination of the completing op.
- `done_data`  out  32  value being written back (equals `alu_res`).
- `dbg_addr`  in  AW  debug read index.
- `dbg_data`  out  32  combinational read of `rf[dbg_addr]`.

## Operation
- Register file: `NREG` x 32-bit entries, all cleared to 0 on reset.
- FSM states:
  - IDLE: `cmd_ready=1`.
  - EXEC: ALU inputs stable; the ALU registers its result at the end of this cycle.
  - WB: `alu_res` is valid and written back.
- IDLE, `cmd_valid & cmd_ld`: `rf[cmd_rd] <= cmd_imm` at the accept edge; FSM stays in IDLE; no done pulse.
- IDLE, `cmd_valid & !cmd_ld`:
  - At the accept edge: `alu_a <= rf[cmd_rs]`, `alu_b <= rf[cmd_rt]`, `alu_op <= cmd_op`; `cmd_rd` is latched.
  - Then IDLE -> EXEC.
- EXEC -> WB unconditionally.
- WB:
  - `done_valid=1`, `done_rd` = latched rd, `done_data=alu_res`.
  - At the end of WB, `rf[rd] <= alu_res` and the FSM returns to IDLE.
- `cmd_ready=0` in EXEC and WB. Commands are held by the source and are neither dropped nor queued.
- Operands are sampled at the accept edge, so `rs==rt`, `rd==rs` and `rd==rt` behave naturally: the old value is read and the new value is written.
- Arithmetic is performed by the ALU, mod 2^32. This block never alters `alu_res`.
- `alu_a`/`alu_b`/`alu_op` hold their last values in IDLE.
- `dbg_data` reflects a write from the cycle after the writing edge.

## Timing
- Reset values: `cmd_ready=1` (IDLE), `done_valid=0`, `done_rd=0`, `done_data` undefined (tracks `alu_res`), `alu_a=alu_b=0`, `alu_op=0`, `rf` all 0.
- ALU command: accept at edge E0 -> EXEC during cycle E0..E1 -> WB during E1..E2 with `done_valid=1` -> register written at E2 -> `cmd_ready=1` from E2.
- Latency is 2 cycles from accept to result visible. Throughput is one ALU command per 3 cycles, or one load per cycle.
- A load immediately followed by an ALU command that reads the same register sees the loaded value.
- `rst_n` asserted in any state: immediate return to IDLE, `done_valid` low, register file cleared. An in-flight writeback is discarded.
- Reset deassertion is synchronised externally. The first command may be accepted at the first rising edge after deassertion.

## Configuration
- `ALU_CTRL_R0_ZERO_EN` defined:
  - register 0 always reads 0 (operand path and `dbg_data`);
  - loads and writebacks to index 0 are discarded;
  - `done_valid` still pulses with `done_rd=0` and `done_data=alu_res`.
- Not defined: register 0 is an ordinary register.

## Test plan
- Load r1=5, load r2=3, then ADD rd=3 rs=1 rt=2 -> `done_valid` exactly 2 cycles after accept with `done_data=8`; `dbg_data(3)=8`; `cmd_ready` low for 2 cycles.
- SUB r4=r2-r1 -> `done_data=0xFFFFFFFE`. Then SLT r5=r4<r1 -> 0 (unsigned). Then XOR r6=r1^r2 -> 6.
- `cmd_valid` held high with 3 ALU commands -> accepts exactly every 3rd cycle; 3 done pulses; no command lost or duplicated.
- ADD r1=r1+r1 with r1=5 -> 10; then ADD r1=r1+r1 -> 20, confirming the writeback precedes the next operand read.
- `rst_n` pulsed low during EXEC of an ADD to r7 -> no `done_valid`; r7=0; all registers 0; `cmd_ready=1` after reset.
- With `ALU_CTRL_R0_ZERO_EN`: load r0=0x55 -> `dbg_data(0)=0`; ADD r0=r1+r2 -> done pulses with `done_data=8` but `dbg_data(0)=0`. Without the macro: `dbg_data(0)=8`.
